lut_neuron_table_loader: RTL and testbench



---
 rtl/lut_neuron_pkg.sv | 24 ++
 rtl/lut_neuron_bank.sv | 34 +++
 rtl/lut_neuron_table_loader.sv | 103 ++++++++++
 tb/tb_lut_neuron_table_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared defaults, derived-size helpers and FSM encoding for the LUT neuron loader.
package lut_neuron_pkg;

  localparam int IN_BITS_DEF  = 6;
  localparam int OUT_BITS_DEF = 2;
  localparam int WORD_W_DEF   = 8;

  // Entries carried by one load-stream word.
  function automatic int calc_epw(input int word_w, input int out_bits);
    return word_w / out_bits;
  endfunction

  // Words needed to cover the whole table.
  function automatic int calc_nw(input int in_bits, input int epw);
    return (1 << in_bits) / epw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/lut_neuron_bank.sv
// One truth-table bank: word-wide write of EPW entries per cycle, async entry read.
// Latency: read is combinational. Backpressure: none; writes land whenever we is high.
module lut_neuron_bank #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2,
  parameter int EPW      = 4,
  parameter int WA       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [WA-1:0]           waddr,
  input  logic [EPW*OUT_BITS-1:0] wdata,
  input  logic [IN_BITS-1:0]      raddr,
  output logic [OUT_BITS-1:0]     rdata
);

  localparam int DEPTH = 2 ** IN_BITS;

  logic [DEPTH-1:0][OUT_BITS-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      for (int j = 0; j < EPW; j++) begin
        mem[IN_BITS'(int'(waddr) * EPW + j)] <= wdata[j*OUT_BITS +: OUT_BITS];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_table_loader.sv
// Double-buffered runtime-loadable neuron LUT: streams a table into the shadow bank, swaps on completion.
// Latency: lookup M0 -> M1 is 1 clock. Backpressure: s_ready high only in LOAD; lookups never stall.
module lut_neuron_table_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS  = IN_BITS_DEF,
  parameter int OUT_BITS = OUT_BITS_DEF,
  parameter int WORD_W   = WORD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic [WORD_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                load_done,
  output logic                busy,
  input  logic [IN_BITS-1:0]  M0,
  output logic [OUT_BITS-1:0] M1
);

  localparam int EPW = calc_epw(WORD_W, OUT_BITS);
  localparam int NW  = calc_nw(IN_BITS, EPW);
  localparam int CW  = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] LAST = CW'(NW - 1);

  state_e                state;
  logic [CW-1:0]         wcnt;
  logic                  sel;
  logic                  wr_ok;
  logic [OUT_BITS-1:0]   rd0;
  logic [OUT_BITS-1:0]   rd1;

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state != ST_IDLE);
  // A restart in the same cycle as a transfer discards that word.
  assign wr_ok   = s_ready & s_valid & ~load_start;

  lut_neuron_bank #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .EPW     (EPW),
    .WA      (CW)
  ) u_bank0 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_ok & sel),
    .waddr(wcnt),
    .wdata(s_data),
    .raddr(M0),
    .rdata(rd0)
  );

  lut_neuron_bank #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .EPW     (EPW),
    .WA      (CW)
  ) u_bank1 (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_ok & ~sel),
    .waddr(wcnt),
    .wdata(s_data),
    .raddr(M0),
    .rdata(rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      sel       <= 1'b0;
      load_done <= 1'b0;
      M1        <= '0;
    end else begin
      load_done <= (state == ST_COMMIT);
      M1        <= sel ? rd1 : rd0;
      case (state)
        ST_IDLE: begin
          if (load_start) begin
            state <= ST_LOAD;
            wcnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            wcnt <= '0;
          end else if (s_valid) begin
            if (wcnt == LAST) state <= ST_COMMIT;
            else              wcnt  <= wcnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          sel   <= ~sel;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Directed bench for lut_neuron_table_loader; lookup results checked through an expected-value queue.
module tb_lut_neuron_table_loader;

  logic       clk;
  logic       rst_n;
  logic       load_start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       load_done;
  logic       busy;
  logic [5:0] m0;
  logic [1:0] m1;

  int total;
  int bad;

  logic [1:0] act [64];
  logic [1:0] shd [64];
  logic [1:0] exp_q [$];

  lut_neuron_table_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .load_done (load_done),
    .busy      (busy),
    .M0        (m0),
    .M1        (m1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: queue the expected lookup, let the edge pass, then compare M1.
  task automatic tick();
    logic [1:0] e;
    exp_q.push_back(act[m0]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("m1", 8'(m1), 8'(e));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    s_valid    = 1'b0;
    tick();
    load_start = 1'b0;
    chk("busy_load", 8'(busy), 8'd1);
  endtask

  task automatic send_word(input logic [7:0] w, input int k, input bit gaps);
    if (gaps) begin
      int n;
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        tick();
      end
    end
    s_valid = 1'b1;
    s_data  = w;
    chk("s_ready_load", 8'(s_ready), 8'd1);
    for (int j = 0; j < 4; j++) shd[k*4+j] = w[j*2 +: 2];
    tick();
    s_valid = 1'b0;
    chk("no_early_done", 8'(load_done), 8'd0);
  endtask

  // Called right after the final transfer has been clocked in.
  task automatic expect_commit();
    chk("busy_commit", 8'(busy), 8'd1);
    chk("rdy_commit", 8'(s_ready), 8'd0);
    tick();
    chk("load_done", 8'(load_done), 8'd1);
    act = shd;
    tick();
    chk("done_one_cycle", 8'(load_done), 8'd0);
    chk("busy_idle", 8'(busy), 8'd0);
  endtask

  task automatic sweep();
    for (int a = 0; a < 64; a++) begin
      m0 = 6'(a);
      tick();
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    load_start = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    m0         = 6'd0;
    for (int i = 0; i < 64; i++) begin
      act[i] = 2'b00;
      shd[i] = 2'b00;
    end

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_m1", 8'(m1), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ready", 8'(s_ready), 8'd0);
    chk("rst_done", 8'(load_done), 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep();
    chk("idle_busy", 8'(busy), 8'd0);
    chk("idle_ready", 8'(s_ready), 8'd0);

    // Full load of 8'hE4, continuous valid
    start_load();
    for (int k = 0; k < 16; k++) send_word(8'hE4, k, 1'b0);
    expect_commit();
    m0 = 6'd5;
    tick();
    chk("e4_addr5", 8'(m1), 8'h01);
    m0 = 6'd63;
    tick();
    chk("e4_addr63", 8'(m1), 8'h03);

    // Reload with gaps while watching address 63: old value until the swap
    start_load();
    for (int k = 0; k < 16; k++) send_word(8'h1B, k, 1'b1);
    expect_commit();
    tick();
    chk("1b_addr63", 8'(m1), 8'h00);

    // Restart after 7 words, then a full zero table
    start_load();
    for (int k = 0; k < 7; k++) send_word(8'h55, k, 1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("restart_busy", 8'(busy), 8'd1);
    for (int k = 0; k < 16; k++) send_word(8'h00, k, 1'b0);
    expect_commit();
    sweep();

    // Restart coinciding with the final transfer: no commit
    start_load();
    for (int k = 0; k < 15; k++) send_word(8'hAA, k, 1'b0);
    load_start = 1'b1;
    s_valid    = 1'b1;
    s_data     = 8'hAA;
    tick();
    load_start = 1'b0;
    s_valid    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("race_no_done", 8'(load_done), 8'd0);
      chk("race_still_load", 8'(s_ready), 8'd1);
    end
    for (int k = 0; k < 16; k++) send_word(8'(k * 17 + 3), k, 1'b0);
    expect_commit();
    sweep();

    // Valid data while idle is ignored
    m0      = 6'd5;
    s_valid = 1'b1;
    s_data  = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      chk("idle_no_ready", 8'(s_ready), 8'd0);
      tick();
      chk("idle_no_busy", 8'(busy), 8'd0);
    end
    s_valid = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a load
    m0 = 6'd0;
    start_load();
    for (int k = 0; k < 10; k++) send_word(8'hFF, k, 1'b0);
    chk("pre_rst_m1", 8'(m1), 8'h03);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_m1", 8'(m1), 8'd0);
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_ready", 8'(s_ready), 8'd0);
    chk("arst_done", 8'(load_done), 8'd0);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      act[i] = 2'b00;
      shd[i] = 2'b00;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep();
    chk("post_rst_busy", 8'(busy), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
